// File: rtl/alu_pkg.sv
// Shared ALU constants: opcodes, flag bit positions and the sticky-flag helper.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_SUB = 4'h1;

  localparam int unsigned FLAG_C = 3;
  localparam int unsigned FLAG_V = 2;
  localparam int unsigned FLAG_Z = 1;
  localparam int unsigned FLAG_N = 0;

  localparam int unsigned FIFO_DEPTH = 2;

  typedef struct packed {
    logic carry;
    logic overflow;
  } sticky_t;

  // Flags that feed the sticky register, packed in sticky port order.
  function automatic sticky_t sticky_hits(input logic [3:0] flags);
    sticky_t s;
    s.carry    = flags[FLAG_C];
    s.overflow = flags[FLAG_V];
    return s;
  endfunction

endpackage

// File: rtl/alu_res_fifo.sv
// Two-entry result FIFO with 1-bit wrapping pointers; head reads as zero when empty.
module alu_res_fifo #(
  parameter int unsigned DW = 40
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o,
  output logic [1:0]    cnt_o,
  output logic [1:0]    cnt_d_o
);

  logic [DW-1:0] mem_q [2];
  logic          wptr_q, rptr_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          do_push, do_pop;

  // Guard against overflow/underflow even if the caller misbehaves.
  assign do_push = push_i && (cnt_q != 2'd2);
  assign do_pop  = pop_i && (cnt_q != 2'd0);

  always_comb begin
    cnt_d = cnt_q;
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wptr_q   <= 1'b0;
      rptr_q   <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= ~wptr_q;
      end
      if (do_pop) begin
        rptr_q <= ~rptr_q;
      end
      cnt_q <= cnt_d;
    end
  end

  assign rdata_o = (cnt_q == 2'd0) ? '0 : mem_q[rptr_q];
  assign cnt_o   = cnt_q;
  assign cnt_d_o = cnt_d;

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: 2-deep output buffer, retired-result counter and sticky C/V flags.
// Sticky flags are built only when ALU_STICKY_FLAGS_EN is defined; otherwise sticky is 0.
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_y,
  input  logic [3:0]           in_flags,
  input  logic [3:0]           in_op,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_y,
  output logic [3:0]           out_flags,
  output logic [3:0]           out_op,
  output logic [CNT_WIDTH-1:0] retired,
  output logic [1:0]           sticky,
  input  logic                 sticky_clr
);

  localparam int unsigned DW = WIDTH + 8;

  logic                 in_ready_q;
  logic [CNT_WIDTH-1:0] retired_q, retired_d;
  logic                 push, pop;
  logic [DW-1:0]        rdata;
  logic [1:0]           cnt, cnt_d;

  assign push = in_valid && in_ready_q;
  assign pop  = out_valid && out_ready;

  alu_res_fifo #(
    .DW (DW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i ({in_op, in_flags, in_y}),
    .rdata_o (rdata),
    .cnt_o   (cnt),
    .cnt_d_o (cnt_d)
  );

  assign out_valid = (cnt != 2'd0);
  assign out_y     = rdata[WIDTH-1:0];
  assign out_flags = rdata[WIDTH+3:WIDTH];
  assign out_op    = rdata[WIDTH+7:WIDTH+4];

  always_comb begin
    retired_d = retired_q;
    if (pop) begin
      retired_d = retired_q + CNT_WIDTH'(1);
    end
  end

  // in_ready looks at next occupancy so it never depends on out_ready in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_ready_q <= 1'b0;
      retired_q  <= '0;
    end else begin
      in_ready_q <= (cnt_d < 2'(FIFO_DEPTH));
      retired_q  <= retired_d;
    end
  end

  assign in_ready = in_ready_q;
  assign retired  = retired_q;

`ifdef ALU_STICKY_FLAGS_EN
  sticky_t sticky_q, sticky_d, hits;

  assign hits = push ? sticky_hits(in_flags) : '0;

  // Any set in the same cycle as a clear suppresses the clear entirely.
  always_comb begin
    sticky_d = sticky_q | hits;
    if (sticky_clr && (hits == '0)) begin
      sticky_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky            = 2'b00;
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed bench for alu_result_stage; sticky expectations follow ALU_STICKY_FLAGS_EN.
module tb_alu_result_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y;
  logic [3:0]  in_flags;
  logic [3:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_y;
  logic [3:0]  out_flags;
  logic [3:0]  out_op;
  logic [15:0] retired;
  logic [1:0]  sticky;
  logic        sticky_clr;

  int checks = 0;
  int errors = 0;

  alu_result_stage #(
    .WIDTH     (32),
    .CNT_WIDTH (16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y       (in_y),
    .in_flags   (in_flags),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_flags  (out_flags),
    .out_op     (out_op),
    .retired    (retired),
    .sticky     (sticky),
    .sticky_clr (sticky_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [31:0] y;
    logic [3:0]  f;
    logic [3:0]  op;
    logic        ordy;
    logic        clr;
    logic        irdy;
    logic        ovld;
    logic [31:0] oy;
    logic [3:0]  oflags;
    logic [3:0]  oop;
    logic [15:0] ret;
    logic [1:0]  stk;
  } vec_t;

  vec_t vecs[13];

  function automatic logic [1:0] exp_stk(input logic [1:0] s);
`ifdef ALU_STICKY_FLAGS_EN
    return s;
`else
    return (s & 2'b00);
`endif
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] y, input logic [3:0] f,
                       input logic [3:0] op, input logic ordy, input logic clr);
    in_valid   = v;
    in_y       = y;
    in_flags   = f;
    in_op      = op;
    out_ready  = ordy;
    sticky_clr = clr;
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] ret0;

    //            v  y             f        op    ordy clr  irdy ovld oy            oflags   oop   ret    stk
    vecs[0]  = '{1, 32'h5,        4'b0000, 4'h0, 1, 0,  1,   1,   32'h5,        4'b0000, 4'h0, 16'd0, 2'b00};
    vecs[1]  = '{0, 32'h0,        4'b0000, 4'h0, 1, 0,  1,   0,   32'h0,        4'b0000, 4'h0, 16'd1, 2'b00};
    vecs[2]  = '{1, 32'h1,        4'b0001, 4'h1, 0, 0,  1,   1,   32'h1,        4'b0001, 4'h1, 16'd1, 2'b00};
    vecs[3]  = '{1, 32'h2,        4'b0010, 4'h0, 0, 0,  0,   1,   32'h1,        4'b0001, 4'h1, 16'd1, 2'b00};
    vecs[4]  = '{1, 32'h3,        4'b0000, 4'h1, 0, 0,  0,   1,   32'h1,        4'b0001, 4'h1, 16'd1, 2'b00};
    vecs[5]  = '{0, 32'h0,        4'b0000, 4'h0, 1, 0,  1,   1,   32'h2,        4'b0010, 4'h0, 16'd2, 2'b00};
    vecs[6]  = '{0, 32'h0,        4'b0000, 4'h0, 1, 0,  1,   0,   32'h0,        4'b0000, 4'h0, 16'd3, 2'b00};
    vecs[7]  = '{1, 32'h8000_0000, 4'b0100, 4'h0, 0, 0, 1,   1,   32'h8000_0000, 4'b0100, 4'h0, 16'd3, 2'b01};
    vecs[8]  = '{1, 32'h0,        4'b1010, 4'h0, 1, 1,  1,   1,   32'h0,        4'b1010, 4'h0, 16'd4, 2'b11};
    vecs[9]  = '{0, 32'h0,        4'b0000, 4'h0, 0, 1,  1,   1,   32'h0,        4'b1010, 4'h0, 16'd4, 2'b00};
    vecs[10] = '{0, 32'h0,        4'b0000, 4'h0, 0, 0,  1,   1,   32'h0,        4'b1010, 4'h0, 16'd4, 2'b00};
    vecs[11] = '{1, 32'h7,        4'b0000, 4'h1, 1, 0,  1,   1,   32'h7,        4'b0000, 4'h1, 16'd5, 2'b00};
    vecs[12] = '{0, 32'h0,        4'b0000, 4'h0, 1, 0,  1,   0,   32'h0,        4'b0000, 4'h0, 16'd6, 2'b00};

    rst = 1'b1;
    drive(0, 32'h0, 4'h0, 4'h0, 0, 0);
    @(negedge clk);
    check("rst.in_ready", 64'(in_ready), 64'd0);
    check("rst.out_valid", 64'(out_valid), 64'd0);
    check("rst.out_y", 64'(out_y), 64'd0);
    check("rst.out_flags", 64'(out_flags), 64'd0);
    check("rst.out_op", 64'(out_op), 64'd0);
    check("rst.retired", 64'(retired), 64'd0);
    check("rst.sticky", 64'(sticky), 64'd0);
    rst = 1'b0;
    #1;
    check("rel.in_ready_low", 64'(in_ready), 64'd0);
    step();
    check("rel.in_ready_high", 64'(in_ready), 64'd1);

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].v, vecs[i].y, vecs[i].f, vecs[i].op, vecs[i].ordy, vecs[i].clr);
      step();
      check($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].irdy));
      check($sformatf("v%0d.out_valid", i), 64'(out_valid), 64'(vecs[i].ovld));
      check($sformatf("v%0d.out_y", i), 64'(out_y), 64'(vecs[i].oy));
      check($sformatf("v%0d.out_flags", i), 64'(out_flags), 64'(vecs[i].oflags));
      check($sformatf("v%0d.out_op", i), 64'(out_op), 64'(vecs[i].oop));
      check($sformatf("v%0d.retired", i), 64'(retired), 64'(vecs[i].ret));
      check($sformatf("v%0d.sticky", i), 64'(sticky), 64'(exp_stk(vecs[i].stk)));
    end

    // Stream at occupancy 1: one in, one out each cycle, no bubbles.
    drive(1, 32'd100, 4'h0, 4'h0, 0, 0);
    step();
    ret0 = retired;
    for (int i = 0; i < 10; i++) begin
      drive(1, 32'd101 + 32'(i), 4'h0, 4'h1, 1, 0);
      step();
      check($sformatf("stream%0d.out_y", i), 64'(out_y), 64'(32'd101 + 32'(i)));
      check($sformatf("stream%0d.out_valid", i), 64'(out_valid), 64'd1);
      check($sformatf("stream%0d.in_ready", i), 64'(in_ready), 64'd1);
    end
    check("stream.retired", 64'(retired), 64'(ret0 + 16'd10));
    drive(0, 32'h0, 4'h0, 4'h0, 1, 0);
    step();
    check("drain.out_valid", 64'(out_valid), 64'd0);
    check("drain.retired", 64'(retired), 64'(ret0 + 16'd11));

    // Counter wrap from all-ones.
    drive(1, 32'h9, 4'h0, 4'h0, 0, 0);
    step();
    drive(0, 32'h0, 4'h0, 4'h0, 1, 0);
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    check("wrap.preload", 64'(retired), 64'hFFFF);
    step();
    check("wrap.retired", 64'(retired), 64'd0);
    check("wrap.out_valid", 64'(out_valid), 64'd0);

    // Fill to two entries with one retired, then reset asynchronously.
    drive(1, 32'hA, 4'h0, 4'h0, 0, 0);
    step();
    drive(1, 32'hB, 4'h0, 4'h0, 1, 0);
    step();
    drive(1, 32'hC, 4'h0, 4'h0, 0, 0);
    step();
    check("full.in_ready", 64'(in_ready), 64'd0);
    check("full.retired", 64'(retired), 64'd1);
    check("full.out_y", 64'(out_y), 64'hB);
    drive(0, 32'h0, 4'h0, 4'h0, 0, 0);
    #2;
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'd0);
    check("midrst.retired", 64'(retired), 64'd0);
    check("midrst.out_y", 64'(out_y), 64'd0);
    check("midrst.in_ready", 64'(in_ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrel.in_ready_low", 64'(in_ready), 64'd0);
    step();
    check("midrel.in_ready_high", 64'(in_ready), 64'd1);
    check("midrel.out_valid", 64'(out_valid), 64'd0);
    drive(1, 32'hD, 4'h0, 4'h1, 0, 0);
    step();
    check("post.out_y", 64'(out_y), 64'hD);
    check("post.out_op", 64'(out_op), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning the ALU data width.
REQ-002 SHALL have parameter CNT_WIDTH, default 16, meaning the retired-result counter width.
REQ-003 SHALL have one clock and an asynchronous, active-high reset: port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_valid, input, 1, ALU result present.
REQ-006 SHALL have port in_ready, output, 1, stage can accept.
REQ-007 SHALL have port in_y, input, WIDTH, ALU result.
REQ-008 SHALL have port in_flags, input, 4, {carry, overflow, zero, negative} from the ALU.
REQ-009 SHALL have port in_op, input, 4, opcode that produced the result.
REQ-010 SHALL have port out_valid, output, 1, registered result available.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts.
REQ-012 SHALL have port out_y, output, WIDTH, registered result.
REQ-013 SHALL have port out_flags, output, 4, registered flags, same bit order as in_flags.
REQ-014 SHALL have port out_op, output, 4, registered opcode.
REQ-015 SHALL have port retired, output, CNT_WIDTH, count of output handshakes.
REQ-016 SHALL have port sticky, output, 2, {sticky_carry, sticky_overflow}.
REQ-017 SHALL have port sticky_clr, input, 1, clear the sticky flags.

Function
REQ-018 SHALL buffer results in a 2-entry FIFO; a push occurs when in_valid && in_ready, and a pop occurs when out_valid && out_ready.
REQ-019 in_ready SHALL be registered and SHALL equal (occupancy < 2); it SHALL NOT depend combinationally on out_ready.
REQ-020 Latency SHALL be 1 cycle: an entry pushed into an empty FIFO SHALL appear on out_* with out_valid=1 on the next clock edge.
REQ-021 out_* SHALL present the oldest entry and SHALL hold it stable while out_valid=1 and out_ready=0.
REQ-022 A simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1, with the new entry becoming head next cycle.
REQ-023 At occupancy 2, in_ready SHALL be 0; a pop SHALL raise in_ready on the following cycle.
REQ-024 At occupancy 0, out_valid SHALL be 0, out_y/out_flags/out_op SHALL be 0, and a pop SHALL be impossible.
REQ-025 retired SHALL increment by 1 on each pop and SHALL wrap from all-ones to 0.
REQ-026 Read/write pointers SHALL be 1 bit each and SHALL wrap modulo 2.

Reset
REQ-027 On rst=1, asynchronously: occupancy=0, pointers=0, in_ready=0, out_valid=0, out_y=0, out_flags=0, out_op=0, retired=0, sticky=0.
REQ-028 in_ready SHALL rise on the first clock edge after rst deasserts.
REQ-029 A reset mid-transfer SHALL discard all buffered entries, with no partial output.

Configuration
REQ-030 Macro ALU_STICKY_FLAGS_EN: when defined, sticky[1] SHALL set on a push with in_flags[3]=1, sticky[0] SHALL set on a push with in_flags[2]=1, and sticky_clr SHALL clear both next cycle.
REQ-031 When a set and sticky_clr occur in the same cycle, the set SHALL win.
REQ-032 Without ALU_STICKY_FLAGS_EN, sticky SHALL be constant 0 and sticky_clr SHALL be ignored; the port list SHALL be unchanged.

Structure
REQ-033 A shared package alu_pkg SHALL hold the opcode constants (OP_ADD=4'h0, OP_SUB=4'h1) and the flag bit indices (FLAG_C=3, FLAG_V=2, FLAG_Z=1, FLAG_N=0).
REQ-034 The FIFO storage and pointers SHALL live in one sub-module, alu_res_fifo, parameterised by data width; counters and sticky logic SHALL stay in the top.

Verification
REQ-035 Single push, out_ready=1: in_y=32'h0000_0005, in_flags=4'b0000, op=0 at cycle N -> out_valid=1 and out_y=5 at N+1, then retired=1.
REQ-036 Backpressure: out_ready=0, three back-to-back pushes (1,2,3) -> in_ready=0 after the second push, the third is not accepted, and out_y holds 1.
REQ-037 Stream at occupancy 1 with in_valid=out_ready=1 for 10 cycles -> outputs appear in order with no bubbles, and retired increases by 10.
REQ-038 Wrap: preload retired to 16'hFFFF (force), one pop -> retired=0.
REQ-039 Sticky (macro on): push with in_flags=4'b0100 (overflow, e.g. 7FFFFFFF+1) -> sticky=2'b01; sticky_clr together with a carry push -> sticky=2'b11; sticky_clr alone -> sticky=2'b00. With the macro off -> sticky stays 0.
REQ-040 Reset mid-operation: occupancy 2, assert rst asynchronously -> out_valid=0 and retired=0 immediately, and in_ready=1 one edge after release.
